// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader. Receives a counted, checksummed byte
// stream over valid/ready, assembles 24-bit {op, data_hi, data_lo} words,
// writes them sequentially into program memory and keeps the processor held
// in reset until a load completes with a matching checksum.
module prog_loader #(
  parameter int WORD_WIDTH    = 24,
  parameter int RAM_ADDR_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0]    mem_data,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     err
);

  // Largest legal word count, widened so it is comparable with any count byte.
  localparam logic [8:0] DEPTH = 9'(2 ** RAM_ADDR_BITS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_BYTES = 3'd2,
    S_WRITE = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t                 state_r;
  logic [1:0]             byte_idx_r;
  logic [15:0]            word_r;
  logic [7:0]             csum_r;
  // One bit wider than mem_addr so a full-depth load does not wrap before the compare.
  logic [RAM_ADDR_BITS:0] widx_r;
  logic [RAM_ADDR_BITS:0] count_r;

  logic                   xfer_s;
  logic                   count_ok_s;
  logic [RAM_ADDR_BITS:0] widx_inc_s;

  // Running mod-256 checksum over word bytes.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  // Handshake, count legality and next word index.
  always_comb begin
    xfer_s     = in_valid && in_ready;
    count_ok_s = (in_data != 8'd0) && ({1'b0, in_data} <= DEPTH);
    widx_inc_s = widx_r + {{RAM_ADDR_BITS{1'b0}}, 1'b1};
  end

  // Load sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      byte_idx_r <= 2'd0;
      word_r     <= 16'd0;
      csum_r     <= 8'd0;
      widx_r     <= '0;
      count_r    <= '0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r  <= S_COUNT;
            in_ready <= 1'b1;
          end
        end
        S_COUNT: begin
          if (xfer_s) begin
            widx_r     <= '0;
            csum_r     <= 8'd0;
            byte_idx_r <= 2'd0;
            if (count_ok_s) begin
              count_r <= in_data[RAM_ADDR_BITS:0];
              state_r <= S_BYTES;
            end else begin
              state_r  <= S_ERR;
              in_ready <= 1'b0;
              err      <= 1'b1;
            end
          end
        end
        S_BYTES: begin
          if (xfer_s) begin
            csum_r <= csum_add(csum_r, in_data);
            if (byte_idx_r == 2'd2) begin
              mem_data   <= {word_r, in_data};
              mem_addr   <= widx_r[RAM_ADDR_BITS-1:0];
              mem_we     <= 1'b1;
              in_ready   <= 1'b0;
              byte_idx_r <= 2'd0;
              state_r    <= S_WRITE;
            end else begin
              word_r     <= {word_r[7:0], in_data};
              byte_idx_r <= byte_idx_r + 2'd1;
            end
          end
        end
        S_WRITE: begin
          widx_r   <= widx_inc_s;
          in_ready <= 1'b1;
          if (widx_inc_s == count_r) begin
            state_r <= S_CHECK;
          end else begin
            state_r <= S_BYTES;
          end
        end
        S_CHECK: begin
          if (xfer_s) begin
            in_ready <= 1'b0;
            if (in_data == csum_r) begin
              state_r  <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state_r <= S_ERR;
              err     <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (start) begin
            state_r  <= S_COUNT;
            in_ready <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
          end
        end
        default: begin
          state_r  <= S_IDLE;
          in_ready <= 1'b0;
          cpu_hold <= 1'b1;
          done     <= 1'b0;
          err      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
module tb_prog_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [23:0] mem_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks;
  int failures;

  // Write capture.
  logic [3:0]  wa_q[$];
  logic [23:0] wd_q[$];
  int          rdy_bad;

  prog_loader #(.WORD_WIDTH(24), .RAM_ADDR_BITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write cycle and flag in_ready seen high during one.
  always @(negedge clk) begin
    if (rst && mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_data);
      if (in_ready !== 1'b0) rdy_bad++;
    end
  end

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    rdy_bad = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte after `gap` idle cycles; returns on the negedge after the transfer.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_byte_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'hxx;
  endtask

  task automatic send_normal(input logic [7:0] cks, input bit gaps);
    logic [7:0] s[8];
    int         g[8];
    s = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, cks};
    g = '{0, 3, 1, 5, 2, 0, 4, 1};
    for (int i = 0; i < 8; i++) send_byte(s[i], gaps ? g[i] : 0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks += 7;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    if (mem_addr !== 4'h0) begin failures++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    if (mem_data !== 24'h0) begin failures++; $display("FAIL rst_mem_data: got %h want 0", mem_data); end
    if (cpu_hold !== 1'b1) begin failures++; $display("FAIL rst_cpu_hold: got %b want 1", cpu_hold); end
    if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", done); end
    if (err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b want 0", err); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_normal(input string name, input bit gaps);
    clear_log();
    pulse_start();
    send_normal(8'h65, gaps);
    checks += 5;
    if (done !== 1'b1) begin failures++; $display("FAIL %s_done: got %b want 1", name, done); end
    if (cpu_hold !== 1'b0) begin failures++; $display("FAIL %s_cpu_hold: got %b want 0", name, cpu_hold); end
    if (err !== 1'b0) begin failures++; $display("FAIL %s_err: got %b want 0", name, err); end
    if (wa_q.size() !== 2) begin failures++; $display("FAIL %s_nwrites: got %0d want 2", name, wa_q.size()); end
    if (rdy_bad !== 0) begin failures++; $display("FAIL %s_ready_in_write: got %0d want 0", name, rdy_bad); end
    if (wa_q.size() >= 2) begin
      checks += 4;
      if (wa_q[0] !== 4'h0) begin failures++; $display("FAIL %s_addr0: got %h want 0", name, wa_q[0]); end
      if (wd_q[0] !== 24'h112233) begin failures++; $display("FAIL %s_data0: got %h want 112233", name, wd_q[0]); end
      if (wa_q[1] !== 4'h1) begin failures++; $display("FAIL %s_addr1: got %h want 1", name, wa_q[1]); end
      if (wd_q[1] !== 24'h445566) begin failures++; $display("FAIL %s_data1: got %h want 445566", name, wd_q[1]); end
    end
  endtask

  task automatic test_bad_checksum();
    clear_log();
    pulse_start();
    checks += 3;
    if (done !== 1'b0) begin failures++; $display("FAIL restart_done: got %b want 0", done); end
    if (cpu_hold !== 1'b1) begin failures++; $display("FAIL restart_cpu_hold: got %b want 1", cpu_hold); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL restart_in_ready: got %b want 1", in_ready); end
    send_normal(8'h00, 1'b0);
    checks += 6;
    if (err !== 1'b1) begin failures++; $display("FAIL badcks_err: got %b want 1", err); end
    if (done !== 1'b0) begin failures++; $display("FAIL badcks_done: got %b want 0", done); end
    if (cpu_hold !== 1'b1) begin failures++; $display("FAIL badcks_cpu_hold: got %b want 1", cpu_hold); end
    if (wa_q.size() !== 2) begin failures++; $display("FAIL badcks_nwrites: got %0d want 2", wa_q.size()); end
    if (wd_q.size() >= 2 && wd_q[1] !== 24'h445566) begin failures++; $display("FAIL badcks_data1: got %h want 445566", wd_q[1]); end
    if (wd_q.size() >= 1 && wd_q[0] !== 24'h112233) begin failures++; $display("FAIL badcks_data0: got %h want 112233", wd_q[0]); end
  endtask

  task automatic test_bad_count(input logic [7:0] n);
    clear_log();
    pulse_start();
    checks += 1;
    if (err !== 1'b0) begin failures++; $display("FAIL cnt%h_err_cleared: got %b want 0", n, err); end
    send_byte(n, 0);
    checks += 4;
    if (err !== 1'b1) begin failures++; $display("FAIL cnt%h_err: got %b want 1", n, err); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL cnt%h_in_ready: got %b want 0", n, in_ready); end
    if (cpu_hold !== 1'b1) begin failures++; $display("FAIL cnt%h_cpu_hold: got %b want 1", n, cpu_hold); end
    repeat (3) @(negedge clk);
    if (wa_q.size() !== 0) begin failures++; $display("FAIL cnt%h_nwrites: got %0d want 0", n, wa_q.size()); end
  endtask

  task automatic test_full();
    logic [7:0] a;
    clear_log();
    pulse_start();
    send_byte(8'h10, 0);
    for (int i = 0; i < 16; i++) begin
      a = 8'(i);
      send_byte(a, 0);
      send_byte(a, 0);
      send_byte(a, 0);
    end
    send_byte(8'h68, 0);
    checks += 3;
    if (done !== 1'b1) begin failures++; $display("FAIL full_done: got %b want 1", done); end
    if (err !== 1'b0) begin failures++; $display("FAIL full_err: got %b want 0", err); end
    if (wa_q.size() !== 16) begin failures++; $display("FAIL full_nwrites: got %0d want 16", wa_q.size()); end
    for (int i = 0; i < 16 && i < wa_q.size(); i++) begin
      checks += 2;
      if (wa_q[i] !== 4'(i)) begin failures++; $display("FAIL full_addr%0d: got %h want %h", i, wa_q[i], 4'(i)); end
      if (wd_q[i] !== 24'(i * 24'h010101)) begin failures++; $display("FAIL full_data%0d: got %h want %h", i, wd_q[i], 24'(i * 24'h010101)); end
    end
  endtask

  task automatic test_reset_midload();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    #2 rst = 1'b0;
    #1;
    checks += 6;
    if (mem_we !== 1'b0) begin failures++; $display("FAIL midrst_mem_we: got %b want 0", mem_we); end
    if (mem_addr !== 4'h0) begin failures++; $display("FAIL midrst_mem_addr: got %h want 0", mem_addr); end
    if (mem_data !== 24'h0) begin failures++; $display("FAIL midrst_mem_data: got %h want 0", mem_data); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
    if (cpu_hold !== 1'b1) begin failures++; $display("FAIL midrst_cpu_hold: got %b want 1", cpu_hold); end
    if (done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b want 0", done); end
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h02;
    repeat (3) @(negedge clk);
    checks += 1;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_needs_start: got %b want 0", in_ready); end
    in_valid = 1'b0;
    test_normal("after_rst", 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rdy_bad  = 0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    rst      = 1'b0;
    test_reset();
    test_normal("normal", 1'b0);
    test_bad_checksum();
    test_bad_count(8'h00);
    test_bad_count(8'h11);
    test_normal("gaps", 1'b1);
    test_full();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader sitting directly upstream of the processor's instruction ROM. It accepts a byte stream over a valid/ready handshake, assembles 24-bit instruction words (op byte + 16-bit data), and writes them sequentially into program memory. It holds the processor in reset until a load completes with a correct checksum.

## Interface
- WORD_WIDTH, 24, instruction word width; fixed at 3 bytes, and any other value is unsupported.
- RAM_ADDR_BITS, 4, program memory address width; depth = 2^RAM_ADDR_BITS words.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin a load session; sampled only in IDLE, DONE or ERR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte; a transfer occurs on an edge where in_valid && in_ready.
- mem_we  out  1  one-cycle program-memory write strobe.
- mem_addr  out  RAM_ADDR_BITS  write address.
- mem_data  out  WORD_WIDTH  write word, {op, data_hi, data_lo}.
- cpu_hold  out  1  active-high reset to processor (ORed into its rst).
- done  out  1  load completed and verified; level output.
- err  out  1  load rejected; level output.

## Operation
- Stream format:
  - Count byte N.
  - N words, each three bytes in the order op, data[15:8], data[7:0].
  - Checksum byte equal to the sum mod 256 of all 3N word bytes. The count byte is excluded from the checksum.
- Legal N: 1..2^RAM_ADDR_BITS. N=0 or N>depth sends the block to ERR immediately after the count byte.
- States:
  - IDLE: in_ready=0. start goes to COUNT.
  - COUNT: in_ready=1. Accept N, clear the checksum and the word address, then go to BYTES or ERR.
  - BYTES: in_ready=1. Shift each accepted byte into the word register and add it to the checksum. The 2-bit byte index runs 0,1,2; after index 2, go to WRITE.
  - WRITE: in_ready=0, mem_we=1 for exactly one cycle, mem_addr = current word index, mem_data = assembled word. Then increment the word index. If words written == N, go to CHECK, else go to BYTES.
  - CHECK: in_ready=1. Accept the checksum byte. Match goes to DONE; mismatch goes to ERR.
  - DONE: done=1, cpu_hold=0. start goes to COUNT.
  - ERR: err=1, cpu_hold=1. start goes to COUNT.
- Restart from DONE or ERR: clears done/err and sets cpu_hold=1 on the edge where start is sampled. The word address restarts at 0.
- Word index width is RAM_ADDR_BITS+1 internally, so N=depth does not wrap before the comparison. mem_addr takes the low RAM_ADDR_BITS bits.
- start asserted in COUNT, BYTES, WRITE or CHECK is ignored.
- in_data is ignored when in_valid=0. Bytes are never dropped while in_ready=1.
- mem_data and mem_addr hold their last values outside WRITE.
- Memory contents from a rejected load are not erased; cpu_hold stays high.

## Timing
- Reset values: state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_data=0, cpu_hold=1, done=0, err=0, checksum=0.
- Asynchronous reset asserted mid-load forces reset values immediately. The session is abandoned and a new start is required.
- All outputs are registered. in_ready depends on state only, with no combinational path from in_valid.
- Latency:
  - The third byte of a word is accepted at edge t. mem_we is high in cycle t+1. in_ready is back to 1 at t+2.
  - The checksum byte is accepted at edge t. done=1 and cpu_hold=0 from cycle t+1.
- Minimum session length with in_valid held high: 1 (start) + 1 + 4N + 1 cycles.

## Test plan
- Normal load, RAM_ADDR_BITS=4: start, then bytes 02, 11 22 33, 44 55 66, checksum 65 -> writes (0, 0x112233) and (1, 0x445566), one mem_we cycle each; done=1, cpu_hold=0, err=0.
- Same stream with checksum 00 -> both writes still occur; err=1, done=0, cpu_hold=1.
- Count 00, and separately count 11h (17) -> err=1 one cycle after the count byte; no mem_we; in_ready=0.
- Stream from the normal-load case with in_valid randomly deasserted for gaps of 0-5 cycles -> identical writes and final outputs; in_ready=0 during each WRITE cycle.
- Full load of N=10h words with data = address×0x010101 -> addresses 0..F in order, no wrap; done=1.
- Assert rst after 4 accepted bytes -> reset values immediately. Then start plus the normal-load stream -> writes begin at addr 0 and the result matches the normal-load case.
